// File: rtl/dec_pkg.sv
// dec_pkg: control-bus address map and master FSM states shared by the dec control blocks.
package dec_pkg;

    localparam logic [2:0] DEC_ADDR_RUN  = 3'd0;
    localparam logic [2:0] DEC_ADDR_DIV  = 3'd1;
    localparam logic [2:0] DEC_ADDR_PER0 = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        WR_PER,
        WR_DIV,
        WR_RUN,
        RD_RUN,
        RD_DIV,
        STOP_WR,
        DONE
    } dec_mst_state_t;

endpackage

// File: rtl/dec_ctl_master.sv
// dec_ctl_master: programs the period table, divider and run bit over the dec control bus.
// Define DEC_CTL_MASTER_READBACK_EN to add run/divider readback with a sticky err flag.
module dec_ctl_master
    import dec_pkg::*;
#(
    parameter int m = 8
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           start,
    input  logic           stop,
    input  logic [4*m-1:0] periods,
    input  logic [1:0]     divider_sel,
    input  logic           run_en,
    output logic           ctl_wr,
    output logic           ctl_rd,
    output logic [2:0]     ctl_addr,
    output logic [31:0]    ctl_wrdata,
    input  logic [31:0]    ctl_rddata,
    output logic           busy,
    output logic           done,
    output logic           err
);

    dec_mst_state_t state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [4*m-1:0] per_q, per_d;
    logic [1:0]     div_q, div_d;
    logic           run_q, run_d;
    logic           err_q, err_d;
    logic [m-1:0]   entry;
    logic           abort;

    assign entry = per_q[idx_q*m +: m];
    // Stop kills the beat of the current cycle combinationally, so an aborted state never strobes.
    assign abort = stop && !(state_q inside {IDLE, STOP_WR, DONE});

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        per_d      = per_q;
        div_d      = div_q;
        run_d      = run_q;
        err_d      = err_q;
        ctl_wr     = 1'b0;
        ctl_rd     = 1'b0;
        ctl_addr   = '0;
        ctl_wrdata = '0;
        busy       = state_q != IDLE;
        done       = state_q == DONE;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = STOP_WR;
                end else if (start) begin
                    per_d   = periods;
                    div_d   = divider_sel;
                    run_d   = run_en;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = WR_PER;
                end
            end
            WR_PER: begin
                ctl_wr     = 1'b1;
                ctl_addr   = DEC_ADDR_PER0 + {1'b0, idx_q};
                ctl_wrdata = 32'(entry);
                idx_d      = idx_q + 2'd1;
                state_d    = idx_q == 2'd3 ? WR_DIV : WR_PER;
            end
            WR_DIV: begin
                ctl_wr     = 1'b1;
                ctl_addr   = DEC_ADDR_DIV;
                ctl_wrdata = {30'b0, div_q};
                state_d    = WR_RUN;
            end
            WR_RUN: begin
                ctl_wr     = 1'b1;
                ctl_addr   = DEC_ADDR_RUN;
                ctl_wrdata = {31'b0, run_q};
`ifdef DEC_CTL_MASTER_READBACK_EN
                state_d    = RD_RUN;
`else
                state_d    = DONE;
`endif
            end
`ifdef DEC_CTL_MASTER_READBACK_EN
            RD_RUN: begin
                ctl_rd   = 1'b1;
                ctl_addr = DEC_ADDR_RUN;
                err_d    = err_q | (ctl_rddata[0] != run_q);
                state_d  = RD_DIV;
            end
            RD_DIV: begin
                ctl_rd   = 1'b1;
                ctl_addr = DEC_ADDR_DIV;
                err_d    = err_q | (ctl_rddata[1:0] != div_q);
                state_d  = DONE;
            end
`endif
            STOP_WR: begin
                ctl_wr   = 1'b1;
                ctl_addr = DEC_ADDR_RUN;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            ctl_wr     = 1'b0;
            ctl_rd     = 1'b0;
            ctl_addr   = '0;
            ctl_wrdata = '0;
            idx_d      = idx_q;
            err_d      = err_q;
            state_d    = STOP_WR;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            per_q   <= '0;
            div_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            div_q   <= div_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

`ifdef DEC_CTL_MASTER_READBACK_EN
    assign err = err_q;
`else
    logic unused_rd;
    assign unused_rd = ^{ctl_rddata, err_q};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_ctl_master.sv
// tb_dec_ctl_master: directed sequences for dec_ctl_master with a queued scoreboard of expected bus events.
module tb_dec_ctl_master;

    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        clrn, start, stop, run_en, corrupt;
    logic [31:0] periods;
    logic [1:0]  divider_sel;
    logic        ctl_wr, ctl_rd, busy, done, err;
    logic [2:0]  ctl_addr;
    logic [31:0] ctl_wrdata, ctl_rddata;
    logic [31:0] mem [8];
    ev_t         exp_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          k;
    logic        rb;

    dec_ctl_master #(.m(8)) dut (
        .clk(clk), .clrn(clrn), .start(start), .stop(stop), .periods(periods),
        .divider_sel(divider_sel), .run_en(run_en), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd),
        .ctl_addr(ctl_addr), .ctl_wrdata(ctl_wrdata), .ctl_rddata(ctl_rddata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ctl_wr) mem[ctl_addr] <= ctl_wrdata;
    always_comb ctl_rddata = !ctl_rd ? 32'h0 : (corrupt && ctl_addr == 3'd1) ? 32'h0 : mem[ctl_addr];

    task automatic push(int kind, logic [2:0] a, logic [31:0] d, int c);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic seq(int kk, logic [31:0] p, logic [1:0] dv, logic rn);
        for (int i = 0; i < 4; i++) push(0, 3'(4 + i), {24'b0, p[i*8 +: 8]}, kk + i);
        push(0, 3'd1, {30'b0, dv}, kk + 4);
        push(0, 3'd0, {31'b0, rn}, kk + 5);
`ifdef DEC_CTL_MASTER_READBACK_EN
        push(1, 3'd0, 32'h0, kk + 6);
        push(1, 3'd1, 32'h0, kk + 7);
        push(2, 3'd0, 32'h0, kk + 8);
`else
        push(2, 3'd0, 32'h0, kk + 6);
`endif
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clrn === 1'b1 && (ctl_wr || ctl_rd || done)) begin
            ev_t e;
            int  kind;
            kind = done ? 2 : ctl_wr ? 0 : 1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0h cyc=%0d expected none",
                         kind, ctl_addr, ctl_wrdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind || (ctl_wr && ctl_rd) || e.cyc != cyc ||
                    (kind < 2 && ctl_addr != e.addr) || (kind == 0 && ctl_wrdata != e.data)) begin
                    n_bad++;
                    $display("FAIL bus_event: got kind=%0d addr=%0d data=%0h cyc=%0d expected kind=%0d addr=%0d data=%0h cyc=%0d",
                             kind, ctl_addr, ctl_wrdata, cyc, e.kind, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
`ifdef DEC_CTL_MASTER_READBACK_EN
        rb = 1'b1;
`else
        rb = 1'b0;
`endif
        clrn = 1'b0; start = 1'b0; stop = 1'b0; corrupt = 1'b0;
        periods = 32'h40302010; divider_sel = 2'd2; run_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", 32'(ctl_wr), 0);
        chk("rst_rd", 32'(ctl_rd), 0);
        chk("rst_addr", 32'(ctl_addr), 0);
        chk("rst_wrdata", ctl_wrdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1 clrn = 1'b1;

        // basic sequence; inputs change after capture and must not reach the bus
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        seq(k, 32'h40302010, 2'd2, 1'b1);
        @(posedge clk); #1 start = 1'b0;
        periods = 32'hdeadbeef; divider_sel = 2'd3; run_en = 1'b0;
        chk("busy_in_seq", 32'(busy), 1);
        repeat (12) @(posedge clk); #1;
        chk("err_clean", 32'(err), 0);
        chk("busy_idle", 32'(busy), 0);

        // readback mismatch on divider, then the next start clears err
        corrupt = 1'b1; periods = 32'h04030201; divider_sel = 2'd1; run_en = 1'b0;
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        seq(k, 32'h04030201, 2'd1, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk); #1;
        chk("err_sticky", 32'(err), 32'(rb));
        corrupt = 1'b0;
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        seq(k, 32'h04030201, 2'd1, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        chk("err_cleared", 32'(err), 0);
        repeat (12) @(posedge clk);

        // stop during the idx 2 period beat
        periods = 32'haabbccdd;
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        push(0, 3'd4, 32'hdd, k);
        push(0, 3'd5, 32'hcc, k + 1);
        push(0, 3'd0, 32'h0, k + 3);
        push(2, 3'd0, 32'h0, k + 4);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk); #1 stop = 1'b1;
        repeat (2) @(posedge clk); #1 stop = 1'b0;
        repeat (6) @(posedge clk);

        // start while busy is dropped
        periods = 32'h11223344; divider_sel = 2'd3; run_en = 1'b1;
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        seq(k, 32'h11223344, 2'd3, 1'b1);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);

        // start and stop together in IDLE
        @(posedge clk); #1 start = 1'b1; stop = 1'b1; k = cyc + 1;
        push(0, 3'd0, 32'h0, k);
        push(2, 3'd0, 32'h0, k + 1);
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (6) @(posedge clk);

        // asynchronous reset at the WR_DIV beat
        periods = 32'h55667788;
        @(posedge clk); #1 start = 1'b1; k = cyc + 1;
        for (int i = 0; i < 4; i++) push(0, 3'(4 + i), {24'b0, periods[i*8 +: 8]}, k + i);
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk); #1 clrn = 1'b0;
        #1;
        chk("arst_wr", 32'(ctl_wr), 0);
        chk("arst_addr", 32'(ctl_addr), 0);
        chk("arst_wrdata", ctl_wrdata, 0);
        chk("arst_busy", 32'(busy), 0);
        @(posedge clk); #1 clrn = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);

        repeat (2) @(posedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_ctl_master.md
DEC_CTL_MASTER -- requirements
Module: dec_ctl_master

Interface
REQ-001 Parameter: m, default 8, period entry width in bits (1..32).
REQ-002 clk  input  1  single clock, all logic rising-edge.
REQ-003 clrn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a full configuration sequence.
REQ-005 stop  input  1  request an abort plus a run=0 write.
REQ-006 periods  input  4*m  period table; entry i is at bits [i*m +: m].
REQ-007 divider_sel  input  2  divider value to program.
REQ-008 run_en  input  1  run value to program at the end of the sequence.
REQ-009 ctl_wr  output  1  control-bus write strobe, one cycle per beat.
REQ-010 ctl_rd  output  1  control-bus read strobe, one cycle per beat.
REQ-011 ctl_addr  output  3  control-bus word address.
REQ-012 ctl_wrdata  output  32  control-bus write data.
REQ-013 ctl_rddata  input  32  control-bus read data, combinational from the slave, valid in the same cycle as ctl_rd.
REQ-014 busy  output  1  a sequence is in progress.
REQ-015 done  output  1  one-cycle pulse when a sequence completes.
REQ-016 err  output  1  sticky readback mismatch flag.

Function
REQ-017 Bus rules: slave has zero wait states; ctl_wr and ctl_rd never both high; at most one beat per cycle; ctl_addr and ctl_wrdata valid only while a strobe is high.
REQ-018 Write data: m-bit entries zero-extended to 32 bits; divider in bits [1:0]; run in bit [0]; all other bits 0.
REQ-019 FSM states: IDLE, WR_PER, WR_DIV, WR_RUN, RD_RUN, RD_DIV, STOP_WR, DONE.
REQ-020 In IDLE, start=1 and stop=0 captures periods, divider_sel and run_en into shadow registers, clears err and enters WR_PER with index 0; the bus never sees later input changes.
REQ-021 WR_PER: writes entry idx to address 4+idx; idx 0..3, one beat per cycle; after idx=3, go to WR_DIV.
REQ-022 WR_DIV: writes address 1; WR_RUN: writes address 0 with the shadow run_en; then go to RD_RUN when readback is compiled in, otherwise DONE.
REQ-023 RD_RUN: ctl_rd at address 0, compare rddata[0] with shadow run_en; RD_DIV: ctl_rd at address 1, compare rddata[1:0] with shadow divider; any mismatch sets err.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 Latency: start accepted at edge k gives write beats in cycles k+1..k+6 (addresses 4,5,6,7,1,0); done is in cycle k+7 without readback, k+9 with readback.
REQ-026 busy=1 in every state except IDLE.
REQ-027 start while busy is ignored and not queued.
REQ-028 stop in any non-IDLE state other than STOP_WR or DONE abandons the sequence at the next edge, with no partial beat, and enters STOP_WR.
REQ-029 stop in IDLE enters STOP_WR; start and stop together in IDLE: stop wins.
REQ-030 STOP_WR: writes address 0 with data 0, then DONE.
REQ-031 stop during STOP_WR or DONE is ignored.

Reset
REQ-032 clrn low asynchronously forces: state IDLE, idx 0, ctl_wr=0, ctl_rd=0, ctl_addr=0, ctl_wrdata=0, busy=0, done=0, err=0, shadows 0.
REQ-033 Reset mid-sequence ends bus activity immediately; no beat is replayed after reset is released.

Configuration
REQ-034 Macro DEC_CTL_MASTER_READBACK_EN defined: RD_RUN, RD_DIV and err are functional.
REQ-035 Macro not defined: the read states are absent, ctl_rd is tied 0, err is tied 0, and ctl_rddata is unused.

Structure
REQ-036 Shared package dec_pkg holds: address constants DEC_ADDR_RUN=0, DEC_ADDR_DIV=1, DEC_ADDR_PER0=4, and the state enum typedef dec_mst_state_t.
REQ-037 Single module, no sub-module; the bus interface stays signal-compatible with the dec control slave.

Verification
REQ-038 m=8, periods={8'h40,8'h30,8'h20,8'h10} (entry 0 = 8'h10), div=2, run_en=1, start pulse: (addr,data) sequence (4,0x10),(5,0x20),(6,0x30),(7,0x40),(1,2),(0,1) in consecutive cycles; done in cycle k+7.
REQ-039 Readback on, slave model returns rddata=0 at address 1: err=1 after RD_DIV and done still pulses; the next start clears err.
REQ-040 stop asserted during the WR_PER beat for idx 2: no write to address 6 or 7; next beat is (0,0); done the cycle after.
REQ-041 start again while busy, and start+stop together in IDLE: the first is ignored; the second gives a single (0,0) write only.
REQ-042 clrn pulsed low at the WR_DIV beat: outputs are 0 within the same cycle; after release, the bus stays idle until a new start.
